// File: rtl/fft_frame_scheduler_if.sv
// Stream link shared by the two requester inputs and the FFT data output.
// tuser carries the channel tag on the FFT side and is unused on requester links.
interface fft_frame_scheduler_if #(
   parameter int W = 16
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;
   logic         tuser;

   modport master (output tdata, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/fft_frame_scheduler.sv
// Programs the shared FFT core, then grants whole frames from two requesters round-robin.
// Optional per-channel completed-frame counters are enabled by defining FRAME_CNT_EN.
module fft_frame_scheduler #(
   parameter int               FFT_POINT = 256,
   parameter int               DATA_W    = 16,
   parameter int               CFG_W     = 16,
   parameter logic [CFG_W-1:0] CFG_INIT  = 16'h0001
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fft_frame_scheduler_if.slave  s0,
   fft_frame_scheduler_if.slave  s1,
   fft_frame_scheduler_if.master m,
   output logic [CFG_W-1:0]      cfg_tdata,
   output logic                  cfg_tvalid,
   input  logic                  cfg_tready,
   input  logic                  cfg_update,
   input  logic [CFG_W-1:0]      cfg_word,
   output logic                  busy,
   output logic                  frame_err
`ifdef FRAME_CNT_EN
   ,
   output logic [15:0]           frame_cnt0,
   output logic [15:0]           frame_cnt1
`endif
);

   localparam int               CNT_W    = $clog2(FFT_POINT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FFT_POINT - 1);

   typedef enum logic [1:0] {RST_CFG, CFG, IDLE, XFER} state_t;

   state_t             state_q, state_d;
   logic [CFG_W-1:0]   cfg_tdata_q, cfg_tdata_d;
   logic [CFG_W-1:0]   shadow_q, shadow_d;
   logic               cfg_tvalid_q, cfg_tvalid_d;
   logic               pending_q, pending_d;
   logic               grant_q, grant_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
`ifdef FRAME_CNT_EN
   logic [15:0]        fcnt0_q, fcnt0_d;
   logic [15:0]        fcnt1_q, fcnt1_d;
`endif

   logic               xfer, sel_valid, sel_last, at_last, hs;
   logic [DATA_W-1:0]  sel_data;

   // Granted channel is passed straight through while a frame is in flight.
   always_comb begin
      xfer      = (state_q == XFER);
      sel_valid = grant_q ? s1.tvalid : s0.tvalid;
      sel_last  = grant_q ? s1.tlast  : s0.tlast;
      sel_data  = grant_q ? s1.tdata  : s0.tdata;
      at_last   = (cnt_q == CNT_LAST);
      hs        = xfer & sel_valid & m.tready;
      m.tdata   = xfer ? sel_data : '0;
      m.tvalid  = xfer & sel_valid;
      m.tlast   = xfer & at_last;
      m.tuser   = grant_q;
      s0.tready = xfer & ~grant_q & m.tready;
      s1.tready = xfer &  grant_q & m.tready;
   end

   always_comb begin
      state_d      = state_q;
      cfg_tdata_d  = cfg_tdata_q;
      cfg_tvalid_d = cfg_tvalid_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      grant_d      = grant_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      if (cfg_update) begin
         shadow_d  = cfg_word;
         pending_d = 1'b1;
      end
      unique case (state_q)
         RST_CFG: begin
            cfg_tdata_d  = CFG_INIT;
            cfg_tvalid_d = 1'b1;
            state_d      = CFG;
         end
         CFG: begin
            if (cfg_tready) begin
               cfg_tvalid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         IDLE: begin
            // pending drops when the word is loaded, so any pulse arriving later
            // (including during CFG or RST_CFG) survives the handshake and is resent.
            if (pending_q) begin
               cfg_tdata_d  = cfg_update ? cfg_word : shadow_q;
               cfg_tvalid_d = 1'b1;
               pending_d    = 1'b0;
               state_d      = CFG;
            end else if (s0.tvalid | s1.tvalid) begin
               grant_d = (s0.tvalid & s1.tvalid) ? ~last_q : s1.tvalid;
               state_d = XFER;
            end
         end
         XFER: begin
            if (hs) begin
               if (sel_last != at_last) err_d = 1'b1;
               if (at_last) begin
                  cnt_d   = '0;
                  last_d  = grant_q;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = RST_CFG;
      endcase
      busy_d = (state_d != IDLE);
   end

`ifdef FRAME_CNT_EN
   always_comb begin
      fcnt0_d = fcnt0_q;
      fcnt1_d = fcnt1_q;
      if (hs && at_last) begin
         if (grant_q) fcnt1_d = fcnt1_q + 1'b1;
         else         fcnt0_d = fcnt0_q + 1'b1;
      end
   end
`endif

   // last_q resets to ch1 so that a simultaneous first request favours ch0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RST_CFG;
         cfg_tdata_q  <= '0;
         cfg_tvalid_q <= 1'b0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         grant_q      <= 1'b0;
         last_q       <= 1'b1;
         cnt_q        <= '0;
         busy_q       <= 1'b1;
         err_q        <= 1'b0;
`ifdef FRAME_CNT_EN
         fcnt0_q      <= '0;
         fcnt1_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cfg_tdata_q  <= cfg_tdata_d;
         cfg_tvalid_q <= cfg_tvalid_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         grant_q      <= grant_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
`ifdef FRAME_CNT_EN
         fcnt0_q      <= fcnt0_d;
         fcnt1_q      <= fcnt1_d;
`endif
      end
   end

   assign cfg_tdata  = cfg_tdata_q;
   assign cfg_tvalid = cfg_tvalid_q;
   assign busy       = busy_q;
   assign frame_err  = err_q;
`ifdef FRAME_CNT_EN
   assign frame_cnt0 = fcnt0_q;
   assign frame_cnt1 = fcnt1_q;
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomised bench for fft_frame_scheduler: per-channel sample streams are checked
// against a frame-level model (sample order, frame boundaries, round-robin, config words).
module tb_fft_frame_scheduler;
   localparam int          N     = 256;
   localparam int          DW    = 16;
   localparam int          CW    = 16;
   localparam int          MAXS  = 4096;
   localparam logic [CW-1:0] CINIT = 16'h0001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_frame_scheduler_if #(.W(DW)) s0_if ();
   fft_frame_scheduler_if #(.W(DW)) s1_if ();
   fft_frame_scheduler_if #(.W(DW)) m_if ();

   logic [CW-1:0] cfg_tdata, cfg_word;
   logic          cfg_tvalid, cfg_tready, cfg_update, busy, frame_err;
`ifdef FRAME_CNT_EN
   logic [15:0]   frame_cnt0, frame_cnt1;
`endif

   fft_frame_scheduler #(.FFT_POINT(N), .DATA_W(DW), .CFG_W(CW), .CFG_INIT(CINIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s0         (s0_if),
      .s1         (s1_if),
      .m          (m_if),
      .cfg_tdata  (cfg_tdata),
      .cfg_tvalid (cfg_tvalid),
      .cfg_tready (cfg_tready),
      .cfg_update (cfg_update),
      .cfg_word   (cfg_word),
      .busy       (busy),
      .frame_err  (frame_err)
`ifdef FRAME_CNT_EN
      ,
      .frame_cnt0 (frame_cnt0),
      .frame_cnt1 (frame_cnt1)
`endif
   );

   // Reference state: source streams, consumption pointers and frame bookkeeping.
   logic [DW-1:0] src [2][MAXS];
   int unsigned   idx [2], out_idx [2], lim [2], frames [2], vprob [2];
   int unsigned   rprob, cprob, in_frame, frame_ch, rr_last, gap;
   int unsigned   cfg_hi, cfg_hs, n_chk, n_fail;
   int            err_at;
   logic          rr_chk, gap_chk, gap_armed, exp_err, cfg_owed, upd_req;
   logic [CW-1:0] exp_cfg, upd_word, last_cfg;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      s0_if.tvalid = (idx[0] < lim[0]) && ($urandom_range(99) < vprob[0]);
      s1_if.tvalid = (idx[1] < lim[1]) && ($urandom_range(99) < vprob[1]);
      s0_if.tdata  = src[0][idx[0] % MAXS];
      s1_if.tdata  = src[1][idx[1] % MAXS];
      s0_if.tlast  = ((idx[0] % N) == N - 1) || (err_at >= 0 && int'(idx[0] % N) == err_at);
      s1_if.tlast  = ((idx[1] % N) == N - 1);
      m_if.tready  = ($urandom_range(99) < rprob);
      cfg_tready   = ($urandom_range(99) < cprob);
      cfg_update   = upd_req;
      cfg_word     = upd_word;
      if (upd_req) begin
         exp_cfg  = upd_word;
         cfg_owed = 1'b1;
         upd_req  = 1'b0;
      end
   endtask

   task automatic sample();
      logic s0hs, s1hs, mhs, rq_last, want_last;
      int unsigned g;
      s0hs = s0_if.tvalid & s0_if.tready;
      s1hs = s1_if.tvalid & s1_if.tready;
      mhs  = m_if.tvalid & m_if.tready;
      check("frame_err", frame_err, exp_err);
      check("tready_excl", s0_if.tready & s1_if.tready, 0);
      if (cfg_tvalid) begin
         cfg_hi++;
         check("no_xfer_in_cfg", m_if.tvalid, 0);
         if (cfg_tready) begin
            check("cfg_tdata", cfg_tdata, exp_cfg);
            last_cfg = cfg_tdata;
            cfg_hs++;
            cfg_owed = 1'b0;
         end
      end
      if (mhs) begin
         g         = m_if.tuser;
         want_last = ((out_idx[g] % N) == N - 1);
         rq_last   = g != 0 ? s1_if.tlast : s0_if.tlast;
         check("src_accept", g != 0 ? s1hs : s0hs, 1);
         check("other_idle", g != 0 ? s0hs : s1hs, 0);
         check("m_tdata", m_if.tdata, src[g][out_idx[g] % MAXS]);
         check("m_tlast", m_if.tlast, want_last);
         if (in_frame == 0) begin
            check("cfg_before_grant", cfg_owed, 0);
            if (rr_chk) check("rr_order", g, 1 - rr_last);
            if (gap_armed) check("frame_gap", gap, 1);
            frame_ch = g;
         end else begin
            check("tuser_hold", g, frame_ch);
         end
         if (rq_last != want_last) exp_err = 1'b1;
         out_idx[g]++;
         in_frame++;
         if (in_frame == N) begin
            in_frame  = 0;
            frames[g]++;
            rr_last   = g;
            gap       = 0;
            gap_armed = gap_chk;
         end
      end else if (in_frame == 0) begin
         gap++;
      end
      if (s0hs) idx[0]++;
      if (s1hs) idx[1]++;
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_frames(input int unsigned n, input int unsigned budget);
      int unsigned target, c;
      target = frames[0] + frames[1] + n;
      c = 0;
      while ((frames[0] + frames[1]) < target && c < budget) begin
         step();
         c++;
      end
      check("frame_timeout", frames[0] + frames[1], target);
   endtask

   initial begin
      int unsigned c, hs0, target, f0_base, f1_base;
      logic p1, p2;
      for (int ch = 0; ch < 2; ch++)
         for (int k = 0; k < MAXS; k++) src[ch][k] = DW'($urandom);
      idx = '{0, 0}; out_idx = '{0, 0}; lim = '{0, 0}; frames = '{0, 0}; vprob = '{0, 0};
      rprob = 100; cprob = 100; in_frame = 0; frame_ch = 0; rr_last = 1; gap = 0;
      cfg_hi = 0; cfg_hs = 0; n_chk = 0; n_fail = 0; err_at = -1;
      rr_chk = 0; gap_chk = 0; gap_armed = 0; exp_err = 0; cfg_owed = 1; upd_req = 0;
      exp_cfg = CINIT; upd_word = '0; last_cfg = '0;
      s0_if.tuser = 1'b0; s1_if.tuser = 1'b0;
      drive();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cfg_tvalid", cfg_tvalid, 0);
      check("rst_cfg_tdata", cfg_tdata, 0);
      check("rst_m_tuser", m_if.tuser, 0);
      check("rst_busy", busy, 1);
      check("rst_frame_err", frame_err, 0);
      check("rst_m_tvalid", m_if.tvalid, 0);
      check("rst_m_tlast", m_if.tlast, 0);
      check("rst_s0_tready", s0_if.tready, 0);
      check("rst_s1_tready", s1_if.tready, 0);
      rst_n = 1'b1;
      repeat (10) step();
      check("init_cfg_cycles", cfg_hi, 1);
      check("init_cfg_hs", cfg_hs, 1);
      check("idle_busy", busy, 0);

      // ch0 alone, two back-to-back frames
      gap_armed = 0; gap_chk = 1; vprob = '{100, 0}; lim[0] += 2 * N;
      run_frames(2, 2000);
      check("ch0_frames", frames[0], 2);
`ifdef FRAME_CNT_EN
      check("frame_cnt0", frame_cnt0, frames[0]);
      check("frame_cnt1", frame_cnt1, frames[1]);
`endif

      // both channels continuously valid: strict alternation
      gap_armed = 0; rr_chk = 1; vprob = '{100, 100}; lim[0] += 2 * N; lim[1] += 2 * N;
      run_frames(4, 3000);

      // ch1 with 50% FFT backpressure
      gap_armed = 0; gap_chk = 0; rr_chk = 0; vprob = '{0, 100}; rprob = 50; lim[1] += N;
      run_frames(1, 2000);

      // random valid / ready on both channels
      vprob = '{70, 60}; rprob = 60; lim[0] += 2 * N; lim[1] += 2 * N;
      run_frames(4, 8000);

      // ch0 raises tlast early at sample 100
      check("err_clean", frame_err, 0);
      err_at = 100; vprob = '{100, 0}; rprob = 80; lim[0] += N;
      run_frames(1, 2000);
      err_at = -1;

      // two config updates mid-frame: only the latest is sent, before the next grant
      vprob = '{100, 0}; rprob = 100; cprob = 50; lim[0] += 2 * N;
      p1 = 0; p2 = 0; hs0 = cfg_hs; target = frames[0] + 2; c = 0;
      while (frames[0] < target && c < 3000) begin
         if (!p1 && in_frame == 50) begin
            upd_req = 1'b1; upd_word = 16'h00A5; p1 = 1'b1;
         end else if (p1 && !p2 && in_frame == 150) begin
            upd_req = 1'b1; upd_word = 16'h00A6; p2 = 1'b1;
         end
         step();
         c++;
      end
      check("cfg_phase_frames", frames[0], target);
      check("cfg_resend_count", cfg_hs - hs0, 1);
      check("cfg_last_word", last_cfg, 16'h00A6);

      // asynchronous reset in the middle of a ch1 frame
      cprob = 100; vprob = '{0, 100}; lim[1] += N; c = 0;
      while (!(in_frame == 30 && frame_ch == 1) && c < 3000) begin
         step();
         c++;
      end
      check("reach_mid_frame", in_frame, 30);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_m_tvalid", m_if.tvalid, 0);
      check("mid_rst_s1_tready", s1_if.tready, 0);
      check("mid_rst_m_tuser", m_if.tuser, 0);
      check("mid_rst_busy", busy, 1);
      check("mid_rst_frame_err", frame_err, 0);
      idx[1] -= 30; out_idx[1] -= 30; in_frame = 0;
      exp_err = 0; rr_last = 1; exp_cfg = CINIT; cfg_owed = 1; gap_armed = 0;
      f0_base = frames[0]; f1_base = frames[1];
      lim[0] += N; vprob = '{100, 100}; rr_chk = 1;
      drive();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_frames(2, 3000);
      check("post_rst_ch0", frames[0] - f0_base, 1);
      check("post_rst_ch1", frames[1] - f1_base, 1);
`ifdef FRAME_CNT_EN
      check("post_rst_cnt0", frame_cnt0, 1);
      check("post_rst_cnt1", frame_cnt1, 1);
`endif
      repeat (5) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
